// File: rtl/ps2_mouse_init.sv
// ps2_mouse_init: PS/2 mouse reset, identify and stream-enable sequencer.
// Define PS2_INIT_WHEEL_EN to add the IntelliMouse wheel-detect steps.
module ps2_mouse_init #(
  parameter logic [25:0] TIMEOUT_CYCLES = 26'd50000000,
  parameter int unsigned RETRY_MAX      = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       TxWrite,
  output logic [7:0] TxData,
  input  logic       TxDone,
  input  logic       TxIdle,
  input  logic       RxValid,
  input  logic [7:0] RxData,
  output logic       Busy,
  output logic       Ready,
  output logic       Error,
  output logic [2:0] ErrCode,
  output logic [7:0] DeviceId
);

  typedef enum logic [1:0] {
    K_SEND,
    K_EXP,
    K_ID
  } kind_e;

  typedef struct packed {
    kind_e      kind;
    logic [7:0] data;
  } step_t;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_TX,
    WAIT_RESP,
    DONE,
    FAIL
  } state_e;

`ifdef PS2_INIT_WHEEL_EN
  localparam int NSTEPS = 21;
`else
  localparam int NSTEPS = 6;
`endif
  localparam int SW = $clog2(NSTEPS);
  localparam logic [SW-1:0] LAST = SW'(NSTEPS - 1);
  localparam logic [7:0] RMAX = 8'(RETRY_MAX);
  localparam logic [25:0] TLIM = TIMEOUT_CYCLES - 26'd1;

  localparam logic [2:0] E_TMO   = 3'd1;
  localparam logic [2:0] E_RETRY = 3'd2;
  localparam logic [2:0] E_BYTE  = 3'd3;
  localparam logic [2:0] E_FC    = 3'd4;

  // Step list ROM; indices past the end are never executed.
  function automatic step_t rom(input int i);
    step_t s;
    s = '{K_EXP, 8'hFA};
    case (i)
      0:  s = '{K_SEND, 8'hFF};
      1:  s = '{K_EXP,  8'hFA};
      2:  s = '{K_EXP,  8'hAA};
      3:  s = '{K_ID,   8'h00};
`ifdef PS2_INIT_WHEEL_EN
      4:  s = '{K_SEND, 8'hF3};
      5:  s = '{K_EXP,  8'hFA};
      6:  s = '{K_SEND, 8'hC8};
      7:  s = '{K_EXP,  8'hFA};
      8:  s = '{K_SEND, 8'hF3};
      9:  s = '{K_EXP,  8'hFA};
      10: s = '{K_SEND, 8'h64};
      11: s = '{K_EXP,  8'hFA};
      12: s = '{K_SEND, 8'hF3};
      13: s = '{K_EXP,  8'hFA};
      14: s = '{K_SEND, 8'h50};
      15: s = '{K_EXP,  8'hFA};
      16: s = '{K_SEND, 8'hF2};
      17: s = '{K_EXP,  8'hFA};
      18: s = '{K_ID,   8'h00};
      19: s = '{K_SEND, 8'hF4};
      20: s = '{K_EXP,  8'hFA};
`else
      4:  s = '{K_SEND, 8'hF4};
      5:  s = '{K_EXP,  8'hFA};
`endif
      default: s = '{K_EXP, 8'hFA};
    endcase
    return s;
  endfunction

  state_e        state;
  logic [SW-1:0] step;
  logic [SW-1:0] send_step;
  logic [25:0]   tmo;
  logic [7:0]    retry;

  step_t s0;
  step_t cur;
  step_t nxt;
  step_t rs;
  logic  last;
  logic  tmo_hit;
  logic  hit;

  // Current, following, first and resend step decode.
  assign s0      = rom(0);
  assign cur     = rom(int'(step));
  assign nxt     = rom(int'(step) + 1);
  assign rs      = rom(int'(send_step));
  assign last    = (step == LAST);
  assign tmo_hit = (tmo == TLIM);
  assign hit     = (cur.kind == K_ID) || (RxData == cur.data);

  // Sequencer: all outputs are registered here.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      step      <= '0;
      send_step <= '0;
      tmo       <= '0;
      retry     <= '0;
      TxWrite   <= 1'b0;
      TxData    <= 8'h00;
      Busy      <= 1'b0;
      Ready     <= 1'b0;
      Error     <= 1'b0;
      ErrCode   <= 3'd0;
      DeviceId  <= 8'h00;
    end else begin
      TxWrite <= 1'b0;
      unique case (state)
        IDLE, DONE, FAIL: begin
          if (Start) begin
            state     <= SEND;
            step      <= '0;
            send_step <= '0;
            tmo       <= '0;
            retry     <= '0;
            TxData    <= s0.data;
            Busy      <= 1'b1;
            Ready     <= 1'b0;
            Error     <= 1'b0;
            ErrCode   <= 3'd0;
          end
        end
        SEND: begin
          if (TxWrite) begin
            state <= WAIT_TX;
            tmo   <= '0;
          end else if (TxIdle) begin
            TxWrite   <= 1'b1;
            send_step <= step;
          end
        end
        WAIT_TX: begin
          if (TxDone) begin
            if (last) begin
              state <= DONE;
              Busy  <= 1'b0;
              Ready <= 1'b1;
            end else begin
              step <= step + SW'(1);
              tmo  <= '0;
              if (nxt.kind == K_SEND) begin
                state  <= SEND;
                TxData <= nxt.data;
              end else begin
                state <= WAIT_RESP;
              end
            end
          end else if (tmo_hit) begin
            state   <= FAIL;
            Busy    <= 1'b0;
            Error   <= 1'b1;
            ErrCode <= E_TMO;
          end else begin
            tmo <= tmo + 26'd1;
          end
        end
        WAIT_RESP: begin
          if (RxValid) begin
            if (hit) begin
              retry <= '0;
              if (cur.kind == K_ID) begin
                DeviceId <= RxData;
              end
              if (last) begin
                state <= DONE;
                Busy  <= 1'b0;
                Ready <= 1'b1;
              end else begin
                step <= step + SW'(1);
                tmo  <= '0;
                if (nxt.kind == K_SEND) begin
                  state  <= SEND;
                  TxData <= nxt.data;
                end
              end
            end else if (RxData == 8'hFE) begin
              if (retry >= RMAX) begin
                state   <= FAIL;
                Busy    <= 1'b0;
                Error   <= 1'b1;
                ErrCode <= E_RETRY;
              end else begin
                retry  <= retry + 8'd1;
                step   <= send_step;
                TxData <= rs.data;
                state  <= SEND;
              end
            end else begin
              state   <= FAIL;
              Busy    <= 1'b0;
              Error   <= 1'b1;
              ErrCode <= (RxData == 8'hFC) ? E_FC : E_BYTE;
            end
          end else if (tmo_hit) begin
            state   <= FAIL;
            Busy    <= 1'b0;
            Error   <= 1'b1;
            ErrCode <= E_TMO;
          end else begin
            tmo <= tmo + 26'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_mouse_init.sv
// tb_ps2_mouse_init: directed vectors against a scripted PS/2 device.
// Build with PS2_INIT_WHEEL_EN to exercise the wheel-detect list.
module tb_ps2_mouse_init;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic       TxWrite;
  logic [7:0] TxData;
  logic       TxDone;
  logic       TxIdle;
  logic       RxValid;
  logic [7:0] RxData;
  logic       Busy;
  logic       Ready;
  logic       Error;
  logic [2:0] ErrCode;
  logic [7:0] DeviceId;

  ps2_mouse_init #(
    .TIMEOUT_CYCLES(26'd100),
    .RETRY_MAX     (3)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .TxWrite (TxWrite),
    .TxData  (TxData),
    .TxDone  (TxDone),
    .TxIdle  (TxIdle),
    .RxValid (RxValid),
    .RxData  (RxData),
    .Busy    (Busy),
    .Ready   (Ready),
    .Error   (Error),
    .ErrCode (ErrCode),
    .DeviceId(DeviceId)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // rep/nrep/sent are MSB-first byte/nibble lists of the given length.
  typedef struct {
    logic [191:0] rep;
    int           rlen;
    logic [47:0]  nrep;
    int           ncmd;
    logic [95:0]  sent;
    int           nsent;
    logic         rdy;
    logic         err;
    logic [2:0]   code;
    logic [7:0]   id;
  } vec_t;

  int n_chk;
  int n_fail;
  int cyc;
  int done_cyc;
  int cmd_i;
  int rep_i;
  logic dev_busy;
  vec_t cur;
  logic [7:0] sent_q[$];

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [191:0] rep, input int rlen,
                              input logic [47:0] nrep, input int ncmd,
                              input logic [95:0] sent, input int nsent,
                              input logic rdy, input logic err,
                              input logic [2:0] code, input logic [7:0] id);
    vec_t v;
    v.rep = rep; v.rlen = rlen;
    v.nrep = nrep; v.ncmd = ncmd;
    v.sent = sent; v.nsent = nsent;
    v.rdy = rdy; v.err = err;
    v.code = code; v.id = id;
    return v;
  endfunction

  // Device model: accepts a byte, reports TxDone, then plays its replies.
  initial begin
    int n;
    TxIdle = 1'b1;
    TxDone = 1'b0;
    RxValid = 1'b0;
    RxData = 8'h00;
    dev_busy = 1'b0;
    forever begin
      @(negedge Clk);
      if (TxWrite) begin
        dev_busy = 1'b1;
        sent_q.push_back(TxData);
        TxIdle = 1'b0;
        @(negedge Clk);
        chk("txwrite_one_cycle", 32'(TxWrite), 32'd0);
        @(negedge Clk);
        TxDone = 1'b1;
        done_cyc = cyc + 1;
        @(negedge Clk);
        TxDone = 1'b0;
        TxIdle = 1'b1;
        n = (cmd_i < cur.ncmd) ?
            int'(cur.nrep[4*(cur.ncmd-1-cmd_i) +: 4]) : 0;
        cmd_i++;
        for (int k = 0; k < n; k++) begin
          @(negedge Clk);
          @(negedge Clk);
          RxValid = 1'b1;
          RxData = (rep_i < cur.rlen) ?
                   cur.rep[8*(cur.rlen-1-rep_i) +: 8] : 8'h00;
          rep_i++;
          @(negedge Clk);
          RxValid = 1'b0;
        end
        dev_busy = 1'b0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic arm(input vec_t v);
    cur = v;
    cmd_i = 0;
    rep_i = 0;
    sent_q.delete();
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while ((Busy || dev_busy) && t < 4000) begin
      @(negedge Clk);
      t++;
    end
    chk({name, "_finish"}, 32'(t < 4000), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string p;
    p = $sformatf("v%0d", idx);
    arm(v);
    pulse_start();
    chk({p, "_busy_start"}, 32'(Busy), 32'd1);
    wait_idle(p);
    chk({p, "_busy"}, 32'(Busy), 32'd0);
    chk({p, "_ready"}, 32'(Ready), 32'(v.rdy));
    chk({p, "_error"}, 32'(Error), 32'(v.err));
    chk({p, "_errcode"}, 32'(ErrCode), 32'(v.code));
    chk({p, "_devid"}, 32'(DeviceId), 32'(v.id));
    chk({p, "_nsent"}, 32'(sent_q.size()), 32'(v.nsent));
    for (int k = 0; k < v.nsent && k < sent_q.size(); k++)
      chk($sformatf("%s_sent%0d", p, k), 32'(sent_q[k]),
          32'(v.sent[8*(v.nsent-1-k) +: 8]));
    @(negedge Clk);
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_txwrite"}, 32'(TxWrite), 32'd0);
    chk({p, "_txdata"}, 32'(TxData), 32'd0);
    chk({p, "_busy"}, 32'(Busy), 32'd0);
    chk({p, "_ready"}, 32'(Ready), 32'd0);
    chk({p, "_error"}, 32'(Error), 32'd0);
    chk({p, "_errcode"}, 32'(ErrCode), 32'd0);
    chk({p, "_devid"}, 32'(DeviceId), 32'd0);
  endtask

`ifdef PS2_INIT_WHEEL_EN
  localparam int NV = 2;
`else
  localparam int NV = 9;
`endif

  initial begin
    vec_t vecs[NV];
    int t;
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    done_cyc = 0;
    cmd_i = 0;
    rep_i = 0;
    Reset = 1'b1;
    Start = 1'b0;
`ifdef PS2_INIT_WHEEL_EN
    vecs[0] = mk(192'hFAAA00FAFAFAFAFAFAFA03FA, 12, 48'h311111121, 9,
                 96'hFFF3C8F364F350F2F4, 9, 1'b1, 1'b0, 3'd0, 8'h03);
    vecs[1] = mk(192'hFAAA00FAFAFAFAFAFA55, 10, 48'h31111111, 8,
                 96'hFFF3C8F364F350F2, 8, 1'b0, 1'b1, 3'd3, 8'h00);
`else
    vecs[0] = mk(192'hFAAA00FA, 4, 48'h31, 2, 96'hFFF4, 2,
                 1'b1, 1'b0, 3'd0, 8'h00);
    vecs[1] = mk(192'hFEFEFAAA00FA, 6, 48'h1131, 4, 96'hFFFFFFF4, 4,
                 1'b1, 1'b0, 3'd0, 8'h00);
    vecs[2] = mk(192'hFEFEFEFE, 4, 48'h1111, 4, 96'hFFFFFFFF, 4,
                 1'b0, 1'b1, 3'd2, 8'h00);
    vecs[3] = mk(192'hFAFC, 2, 48'h2, 1, 96'hFF, 1,
                 1'b0, 1'b1, 3'd4, 8'h00);
    vecs[4] = mk(192'h55AA00, 3, 48'h3, 1, 96'hFF, 1,
                 1'b0, 1'b1, 3'd3, 8'h00);
    vecs[5] = mk(192'hFAAA5AFA, 4, 48'h31, 2, 96'hFFF4, 2,
                 1'b1, 1'b0, 3'd0, 8'h5A);
    vecs[6] = mk(192'hFAAA0055, 4, 48'h31, 2, 96'hFFF4, 2,
                 1'b0, 1'b1, 3'd3, 8'h00);
    vecs[7] = mk(192'hFAAA00FEFA, 5, 48'h311, 3, 96'hFFF4F4, 3,
                 1'b1, 1'b0, 3'd0, 8'h00);
    vecs[8] = mk(192'h0, 0, 48'h0, 1, 96'hFF, 1,
                 1'b0, 1'b1, 3'd1, 8'h00);
`endif

    repeat (3) @(negedge Clk);
    chk_zero("in_reset");
    Reset = 1'b0;
    @(negedge Clk);
    chk_zero("after_reset");

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // No reply after FF: Error must rise exactly 100 cycles after TxDone.
    arm(mk(192'h0, 0, 48'h0, 1, 96'hFF, 1, 1'b0, 1'b1, 3'd1, 8'h00));
    pulse_start();
    t = 0;
    while (!Error && t < 500) begin
      @(negedge Clk);
      t++;
    end
    chk("tmo_seen", 32'(Error), 32'd1);
    chk("tmo_latency", 32'(cyc - done_cyc), 32'd100);
    chk("tmo_errcode", 32'(ErrCode), 32'd1);
    chk("tmo_busy", 32'(Busy), 32'd0);
    wait_idle("tmo");

`ifndef PS2_INIT_WHEEL_EN
    // Start while busy must not restart the sequence.
    arm(vecs[0]);
    pulse_start();
    t = 0;
    while (sent_q.size() < 1 && t < 1000) begin
      @(negedge Clk);
      t++;
    end
    pulse_start();
    wait_idle("ign");
    chk("ign_nsent", 32'(sent_q.size()), 32'd2);
    chk("ign_ready", 32'(Ready), 32'd1);
    @(negedge Clk);

    // Reset while waiting for the F4 ack aborts; Start reruns from FF.
    arm(mk(192'hFAAA5A, 3, 48'h30, 2, 96'hFFF4, 2,
           1'b0, 1'b0, 3'd0, 8'h5A));
    pulse_start();
    t = 0;
    while (!(sent_q.size() == 2 && !dev_busy) && t < 2000) begin
      @(negedge Clk);
      t++;
    end
    chk("rst_reach_f4", 32'(sent_q.size()), 32'd2);
    chk("rst_pre_devid", 32'(DeviceId), 32'h5A);
    Reset = 1'b1;
    @(negedge Clk);
    chk_zero("rst_mid");
    Reset = 1'b0;
    repeat (20) @(negedge Clk);
    chk("rst_no_txwrite", 32'(sent_q.size()), 32'd2);
    chk("rst_idle_busy", 32'(Busy), 32'd0);
    run_vec(vecs[0], 99);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
